md_unit: RTL and testbench

- Iterative multiply/divide unit with architectural HI/LO registers.
- Sits directly downstream of the ALU control decoder in the EX stage.
- Consumes the decoder's mult/div flag and 4-bit operation code, plus the mfhi/mflo/mthi/mtlo strobes.
- Runs mult/multu/div/divu over WIDTH+1 cycles and drives a stall to the pipeline while busy.

---
 rtl/md_pkg.sv | 27 ++
 rtl/md_iter_core.sv | 63 ++++++
 rtl/md_unit.sv | 116 +++++++++++
 tb/tb_md_unit.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, decode helpers and FSM states.
package md_pkg;

  localparam logic [3:0] MD_MULT  = 4'b0000;
  localparam logic [3:0] MD_MULTU = 4'b1000;
  localparam logic [3:0] MD_DIV   = 4'b0001;
  localparam logic [3:0] MD_DIVU  = 4'b1001;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } md_state_e;

  function automatic logic is_div(input logic [3:0] op);
    return op[0];
  endfunction

  function automatic logic is_unsigned(input logic [3:0] op);
    return op[3];
  endfunction

  function automatic logic is_legal(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_iter_core.sv
// Unsigned radix-2 iteration datapath: shift-add multiply or restoring divide,
// sharing one 2*WIDTH accumulator (upper half = partial product / remainder).
module md_iter_core import md_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_i,
  input  logic                 step_i,
  input  logic                 div_i,
  input  logic [WIDTH-1:0]     a_mag_i,
  input  logic [WIDTH-1:0]     b_mag_i,
  output logic                 last_o,
  output logic [2*WIDTH-1:0]   prod_o,
  output logic [WIDTH-1:0]     quot_o,
  output logic [WIDTH-1:0]     rem_o
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q;
  logic               div_q;
  logic [CW-1:0]      cnt_q;

  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     shifted;
  logic [WIDTH-1:0]   rem_next;
  logic               ge;

  always_comb begin
    add_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    shifted  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    ge       = (shifted >= {1'b0, opnd_q});
    // The true difference is below the divisor, so WIDTH bits always hold it.
    rem_next = ge ? (shifted[WIDTH-1:0] - opnd_q) : shifted[WIDTH-1:0];
    if (div_q) acc_d = {rem_next, acc_q[WIDTH-2:0], ge};
    else       acc_d = {add_sum, acc_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= '0;
      opnd_q <= '0;
      div_q  <= 1'b0;
      cnt_q  <= '0;
    end else if (load_i) begin
      acc_q  <= {{WIDTH{1'b0}}, (div_i ? a_mag_i : b_mag_i)};
      opnd_q <= div_i ? b_mag_i : a_mag_i;
      div_q  <= div_i;
      cnt_q  <= '0;
    end else if (step_i) begin
      acc_q  <= acc_d;
      cnt_q  <= cnt_q + CW'(1);
    end
  end

  assign last_o = (cnt_q == CW'(WIDTH - 1));
  assign prod_o = acc_q;
  assign quot_o = acc_q[WIDTH-1:0];
  assign rem_o  = acc_q[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/md_unit.sv
// EX-stage multiply/divide unit: FSM, sign handling, HI/LO registers, read mux and stall.
module md_unit import md_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  input  logic             mfhi,
  input  logic             mflo,
  output logic [WIDTH-1:0] rdata,
  output logic             busy,
  output logic             stall
);

  md_state_e          state_q, state_d;
  logic               busy_q, busy_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               op_div_q, sign_q, rsign_q, div0_q;

  logic               a_neg, b_neg, load, step, last;
  logic [WIDTH-1:0]   a_mag, b_mag, quot_raw, rem_raw, quot_fix, rem_fix;
  logic [2*WIDTH-1:0] prod_raw, prod_fix;

  assign a_neg = ~is_unsigned(op) & a[WIDTH-1];
  assign b_neg = ~is_unsigned(op) & b[WIDTH-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;
  assign load  = (state_q == IDLE) & start & is_legal(op);
  assign step  = (state_q == RUN);

  md_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load),
    .step_i  (step),
    .div_i   (is_div(op)),
    .a_mag_i (a_mag),
    .b_mag_i (b_mag),
    .last_o  (last),
    .prod_o  (prod_raw),
    .quot_o  (quot_raw),
    .rem_o   (rem_raw)
  );

  // Divide by zero: the raw core result already is {rem=|a|, quot=all ones};
  // re-applying the dividend sign to the remainder restores a exactly.
  assign prod_fix = sign_q ? -prod_raw : prod_raw;
  assign quot_fix = (sign_q & ~div0_q) ? -quot_raw : quot_raw;
  assign rem_fix  = rsign_q ? -rem_raw : rem_raw;

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      IDLE: begin
        if (load) begin
          state_d = RUN;
        end else if (!start) begin
          if (mthi) hi_d = wdata;
          if (mtlo) lo_d = wdata;
        end
      end
      RUN: begin
        if (last) state_d = FIX;
      end
      FIX: begin
        state_d = IDLE;
        if (op_div_q) begin
          hi_d = rem_fix;
          lo_d = quot_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      op_div_q <= 1'b0;
      sign_q   <= 1'b0;
      rsign_q  <= 1'b0;
      div0_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      if (load) begin
        op_div_q <= is_div(op);
        sign_q   <= a_neg ^ b_neg;
        rsign_q  <= a_neg;
        div0_q   <= (b == '0);
      end
    end
  end

  assign busy  = busy_q;
  assign stall = busy_q & (start | mfhi | mflo | mthi | mtlo);
  assign rdata = mfhi ? hi_q : (mflo ? lo_q : '0);

endmodule

// File: tb/tb_md_unit.sv
// Randomized self-checking bench for md_unit against a plain-arithmetic HI/LO model.
module tb_md_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, start, mthi, mtlo, mfhi, mflo;
  logic [3:0]   op;
  logic [W-1:0] a, b, wdata, rdata;
  logic         busy, stall;

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] m_hi, m_lo;
  logic [3:0]   ops [4] = '{4'b0000, 4'b1000, 4'b0001, 4'b1001};

  always #5 clk = ~clk;

  md_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .mthi  (mthi),
    .mtlo  (mtlo),
    .wdata (wdata),
    .mfhi  (mfhi),
    .mflo  (mflo),
    .rdata (rdata),
    .busy  (busy),
    .stall (stall)
  );

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: MIPS-style HI/LO results from ordinary 64-bit arithmetic.
  task automatic model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    longint     sx, sy;
    logic [63:0] p, q, r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      4'b0000: begin p = sx * sy; m_hi = p[63:32]; m_lo = p[31:0]; end
      4'b1000: begin p = {32'h0, x} * {32'h0, y}; m_hi = p[63:32]; m_lo = p[31:0]; end
      4'b0001: begin
        if (y == 0) begin m_lo = '1; m_hi = x; end
        else begin q = sx / sy; r = sx % sy; m_lo = q[31:0]; m_hi = r[31:0]; end
      end
      default: begin
        if (y == 0) begin m_lo = '1; m_hi = x; end
        else begin m_lo = x / y; m_hi = x % y; end
      end
    endcase
  endtask

  function automatic logic [W-1:0] pick_val();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return 32'h8000_0000;
      2:       return '1;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Launch one operation, hold mfhi through it, optionally inject ignored strobes while busy.
  task automatic run_op(input string tag, input logic [3:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y, input bit noise);
    logic [W-1:0] old_hi;
    int cyc, bad_stall, bad_rd;
    old_hi = m_hi;
    op = o; a = x; b = y; start = 1'b1;
    tick;
    start = 1'b0; a = $urandom; b = $urandom; mfhi = 1'b1;
    model(o, x, y);
    cyc = 0; bad_stall = 0; bad_rd = 0;
    #0;
    while (busy === 1'b1 && cyc < 100) begin
      cyc++;
      if (stall !== 1'b1) bad_stall++;
      if (rdata !== old_hi) bad_rd++;
      if (noise && cyc < 30) begin
        start = 1'($urandom_range(0, 1));
        op    = 4'($urandom_range(0, 15));
        mthi  = 1'($urandom_range(0, 1));
        mtlo  = (cyc == 5) ? 1'b1 : 1'($urandom_range(0, 1));
        wdata = $urandom;
      end else begin
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
      end
      tick;
    end
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    #1;
    $display("op %s op=%b a=%h b=%h -> hi=%h lo=%h busy_cycles=%0d", tag, o, x, y, m_hi, m_lo, cyc);
    check({tag, " busy_cycles"}, 32'(cyc), 32'd33);
    check({tag, " stall_while_busy_errs"}, 32'(bad_stall), 32'd0);
    check({tag, " old_rdata_errs"}, 32'(bad_rd), 32'd0);
    check({tag, " stall_after"}, {31'b0, stall}, 32'd0);
    check({tag, " hi"}, rdata, m_hi);
    mfhi = 1'b0; mflo = 1'b1;
    #1;
    check({tag, " lo"}, rdata, m_lo);
    mflo = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mthi = 1'b0; mtlo = 1'b0; mfhi = 1'b0; mflo = 1'b0;
    op = '0; a = '0; b = '0; wdata = '0;
    m_hi = '0; m_lo = '0;
    tick; tick;
    rst = 1'b0;

    check("reset busy", {31'b0, busy}, 32'd0);
    mfhi = 1'b1;
    #1;
    check("reset stall", {31'b0, stall}, 32'd0);
    check("reset hi", rdata, 32'd0);
    mfhi = 1'b0; mflo = 1'b1;
    #1;
    check("reset lo", rdata, 32'd0);
    mflo = 1'b0;
    #1;
    check("no read rdata", rdata, 32'd0);

    op = 4'b0010; start = 1'b1;
    tick;
    start = 1'b0;
    $display("illegal op start busy=%b", busy);
    check("illegal op busy", {31'b0, busy}, 32'd0);

    run_op("mult", 4'b0000, 32'hFFFF_FFFD, 32'd5, 1'b1);
    run_op("multu", 4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op("div", 4'b0001, 32'hFFFF_FFF9, 32'd2, 1'b1);
    run_op("divu_by0", 4'b1001, 32'd7, 32'd0, 1'b0);
    run_op("div_ovf", 4'b0001, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op("div_by0_neg", 4'b0001, 32'hFFFF_FF00, 32'd0, 1'b0);

    wdata = 32'h1234_5678; mthi = 1'b1;
    tick;
    mthi = 1'b0; m_hi = 32'h1234_5678;
    mflo = 1'b1;
    #1;
    $display("mthi wdata=12345678 lo=%h", rdata);
    check("mthi lo_unchanged", rdata, m_lo);
    mflo = 1'b0; mfhi = 1'b1;
    #1;
    check("mthi hi", rdata, m_hi);
    mflo = 1'b1;
    #1;
    check("mfhi+mflo selects hi", rdata, m_hi);
    mfhi = 1'b0; mflo = 1'b0;

    wdata = 32'hCAFE_F00D; mthi = 1'b1; mtlo = 1'b1;
    tick;
    mthi = 1'b0; mtlo = 1'b0; m_hi = 32'hCAFE_F00D; m_lo = 32'hCAFE_F00D;
    mfhi = 1'b1;
    #1;
    $display("mthi+mtlo wdata=cafef00d");
    check("mthi+mtlo hi", rdata, m_hi);
    mfhi = 1'b0; mflo = 1'b1;
    #1;
    check("mthi+mtlo lo", rdata, m_lo);
    mflo = 1'b0;

    op = 4'b0000; a = 32'd1234; b = 32'd5678; start = 1'b1;
    tick;
    start = 1'b0;
    repeat (9) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0; m_hi = '0; m_lo = '0;
    mfhi = 1'b1;
    #1;
    $display("reset mid-op busy=%b", busy);
    check("midop reset busy", {31'b0, busy}, 32'd0);
    check("midop reset hi", rdata, 32'd0);
    mfhi = 1'b0; mflo = 1'b1;
    #1;
    check("midop reset lo", rdata, 32'd0);
    mflo = 1'b0;
    run_op("divu_after_reset", 4'b1001, 32'd100, 32'd7, 1'b0);

    for (int i = 0; i < 40; i++) begin
      run_op($sformatf("rand%0d", i), ops[$urandom_range(0, 3)], pick_val(), pick_val(),
             1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
